// File: rtl/bram_dp_port_arbiter.sv
// Round-robin arbiter sharing one synchronous BRAM port between two valid/ready requesters.
// Registers the winning request onto the port and routes read data back via a tag pipeline.
module bram_dp_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,

    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic                  r0_wr,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_data_in,
    output logic                  r0_rsp_valid,
    output logic [DATA_WIDTH-1:0] r0_data_out,

    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic                  r1_wr,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_data_in,
    output logic                  r1_rsp_valid,
    output logic [DATA_WIDTH-1:0] r1_data_out,

    output logic                  bram_wr,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_data_in,
    input  logic [DATA_WIDTH-1:0] bram_data_out
);

    // prio_q: 0 favours requester 0, 1 favours requester 1 when both are valid
    logic                  prio_q, prio_d;
    logic                  iss_act_q, iss_act_d;
    logic                  iss_rd_q, iss_rd_d;
    logic                  iss_own_q, iss_own_d;
    logic                  bram_wr_q, bram_wr_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_WIDTH-1:0] bram_data_q, bram_data_d;
    logic                  rsp_rd_q, rsp_rd_d;
    logic                  rsp_own_q, rsp_own_d;

    logic gnt0, gnt1;

    // Readys are forced low during reset so every output reads 0 while rst is high
    always_comb begin
        gnt0 = ~rst & en & r0_valid & (~r1_valid | ~prio_q);
        gnt1 = ~rst & en & r1_valid & (~r0_valid | prio_q);
    end

    always_comb begin
        prio_d      = prio_q;
        iss_act_d   = gnt0 | gnt1;
        iss_rd_d    = 1'b0;
        iss_own_d   = 1'b0;
        bram_wr_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        bram_data_d = bram_data_q;
        if (gnt0) begin
            prio_d      = 1'b1;
            iss_rd_d    = ~r0_wr;
            bram_wr_d   = r0_wr;
            bram_addr_d = r0_addr;
            bram_data_d = r0_data_in;
        end else if (gnt1) begin
            prio_d      = 1'b0;
            iss_rd_d    = ~r1_wr;
            iss_own_d   = 1'b1;
            bram_wr_d   = r1_wr;
            bram_addr_d = r1_addr;
            bram_data_d = r1_data_in;
        end
        rsp_rd_d  = iss_act_q & iss_rd_q;
        rsp_own_d = iss_own_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q      <= 1'b0;
            iss_act_q   <= 1'b0;
            iss_rd_q    <= 1'b0;
            iss_own_q   <= 1'b0;
            bram_wr_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_data_q <= '0;
            rsp_rd_q    <= 1'b0;
            rsp_own_q   <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            iss_act_q   <= iss_act_d;
            iss_rd_q    <= iss_rd_d;
            iss_own_q   <= iss_own_d;
            bram_wr_q   <= bram_wr_d;
            bram_addr_q <= bram_addr_d;
            bram_data_q <= bram_data_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_own_q   <= rsp_own_d;
        end
    end

    always_comb begin
        r0_ready     = gnt0;
        r1_ready     = gnt1;
        bram_wr      = bram_wr_q;
        bram_addr    = bram_addr_q;
        bram_data_in = bram_data_q;
        r0_rsp_valid = rsp_rd_q & ~rsp_own_q;
        r1_rsp_valid = rsp_rd_q & rsp_own_q;
        r0_data_out  = r0_rsp_valid ? bram_data_out : '0;
        r1_data_out  = r1_rsp_valid ? bram_data_out : '0;
    end

endmodule

// File: tb/tb_bram_dp_port_arbiter.sv
// Directed bench for bram_dp_port_arbiter with a BRAM model and a transaction-level reference.
module tb_bram_dp_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst, en;
    logic          r0_valid, r0_ready, r0_wr, r0_rsp_valid;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_data_in, r0_data_out;
    logic          r1_valid, r1_ready, r1_wr, r1_rsp_valid;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_data_in, r1_data_out;
    logic          bram_wr;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_data_in, bram_data_out;

    int n_vec  = 0;
    int n_miss = 0;

    bram_dp_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_wr(r0_wr), .r0_addr(r0_addr),
        .r0_data_in(r0_data_in), .r0_rsp_valid(r0_rsp_valid), .r0_data_out(r0_data_out),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_wr(r1_wr), .r1_addr(r1_addr),
        .r1_data_in(r1_data_in), .r1_rsp_valid(r1_rsp_valid), .r1_data_out(r1_data_out),
        .bram_wr(bram_wr), .bram_addr(bram_addr), .bram_data_in(bram_data_in),
        .bram_data_out(bram_data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] seed_word(int a);
        return 32'hA5A5_0000 | a;
    endfunction

    // Synchronous BRAM port: write commits at the edge, read data registered one cycle
    logic [DW-1:0] bram_mem [1024];
    bit            bram_seeded = 1'b0;
    always @(posedge clk) begin
        if (!bram_seeded) begin
            for (int i = 0; i < 1024; i++) bram_mem[i] <= seed_word(i);
            bram_seeded <= 1'b1;
        end else begin
            if (bram_wr) bram_mem[bram_addr] <= bram_data_in;
            bram_data_out <= bram_mem[bram_addr];
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one accepted operation per cycle, traced through issue and response slots
    typedef struct packed {
        logic          act;
        logic          rd;
        logic          own;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] rdat;
    } op_t;

    op_t           st1, st2, nxt;
    logic [DW-1:0] ref_mem [1024];
    bit            ref_seeded = 1'b0;
    int            m_prio = 0;
    logic [AW-1:0] hold_addr = '0;
    logic [DW-1:0] hold_data = '0;

    always @(negedge clk) begin
        int win;
        logic exp_v0, exp_v1;
        if (!ref_seeded) begin
            for (int i = 0; i < 1024; i++) ref_mem[i] = seed_word(i);
            ref_seeded = 1'b1;
        end
        if (rst) begin
            chk("rst r0_ready", r0_ready, 0);
            chk("rst r1_ready", r1_ready, 0);
            chk("rst bram_wr", bram_wr, 0);
            chk("rst bram_addr", bram_addr, 0);
            chk("rst bram_data_in", bram_data_in, 0);
            chk("rst r0_rsp_valid", r0_rsp_valid, 0);
            chk("rst r1_rsp_valid", r1_rsp_valid, 0);
            chk("rst r0_data_out", r0_data_out, 0);
            chk("rst r1_data_out", r1_data_out, 0);
            st1 = '0; st2 = '0; m_prio = 0; hold_addr = '0; hold_data = '0;
        end else begin
            if (!en) win = -1;
            else if (r0_valid && r1_valid) win = m_prio;
            else if (r0_valid) win = 0;
            else if (r1_valid) win = 1;
            else win = -1;
            chk("r0_ready", r0_ready, (win == 0) ? 1 : 0);
            chk("r1_ready", r1_ready, (win == 1) ? 1 : 0);

            if (st1.act) begin
                hold_addr = st1.addr;
                hold_data = st1.data;
            end
            chk("bram_wr", bram_wr, (st1.act && !st1.rd) ? 1 : 0);
            chk("bram_addr", bram_addr, hold_addr);
            chk("bram_data_in", bram_data_in, hold_data);

            exp_v0 = st2.act && st2.rd && !st2.own;
            exp_v1 = st2.act && st2.rd && st2.own;
            chk("r0_rsp_valid", r0_rsp_valid, exp_v0);
            chk("r1_rsp_valid", r1_rsp_valid, exp_v1);
            chk("r0_data_out", r0_data_out, exp_v0 ? st2.rdat : 0);
            chk("r1_data_out", r1_data_out, exp_v1 ? st2.rdat : 0);

            // The op in the issue slot touches memory at the coming edge
            if (st1.act) begin
                if (st1.rd) st1.rdat = ref_mem[st1.addr];
                else ref_mem[st1.addr] = st1.data;
            end
            st2 = st1;
            nxt = '0;
            if (win == 0) begin
                nxt.act = 1'b1; nxt.rd = !r0_wr; nxt.own = 1'b0;
                nxt.addr = r0_addr; nxt.data = r0_data_in;
            end else if (win == 1) begin
                nxt.act = 1'b1; nxt.rd = !r1_wr; nxt.own = 1'b1;
                nxt.addr = r1_addr; nxt.data = r1_data_in;
            end
            st1 = nxt;
            if (win >= 0) m_prio = 1 - win;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0;
        r0_valid = 0; r0_wr = 0; r0_addr = '0; r0_data_in = '0;
        r1_valid = 0; r1_wr = 0; r1_addr = '0; r1_data_in = '0;
        step(); step();
        rst = 1'b0; en = 1'b1;
        step();

        // r0 write then read-back of the same address
        r0_valid = 1; r0_wr = 1; r0_addr = 10'h006; r0_data_in = 32'hDEADBEEF;
        step();
        r0_wr = 0;
        @(negedge clk);
        chk("t1 bram_wr", bram_wr, 1);
        chk("t1 bram_addr", bram_addr, 10'h006);
        step();
        r0_valid = 0;
        step();
        @(negedge clk);
        chk("t1 r0_rsp_valid", r0_rsp_valid, 1);
        chk("t1 r0_data_out", r0_data_out, 32'hDEADBEEF);
        chk("t1 r1_rsp_valid", r1_rsp_valid, 0);
        step();

        // r1 alone, back-to-back reads
        r1_valid = 1; r1_wr = 0; r1_addr = 10'h055;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3 r1_ready", r1_ready, 1);
            step();
        end
        r1_valid = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t3 r1_rsp_valid", r1_rsp_valid, 1);
            chk("t3 r1_data_out", r1_data_out, 32'hA5A5_0055);
            step();
        end
        @(negedge clk);
        chk("t3 r1_rsp_valid end", r1_rsp_valid, 0);
        step();

        // Both requesters contending: strict alternation starting with r0
        r0_valid = 1; r0_wr = 0; r0_addr = 10'h010;
        r1_valid = 1; r1_wr = 0; r1_addr = 10'h020;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i % 2 == 0) chk("t2 r0_ready", r0_ready, 1);
            else chk("t2 r1_ready", r1_ready, 1);
            step();
        end
        r0_valid = 0; r1_valid = 0;
        @(negedge clk);
        chk("t2 r0_data_out", r0_data_out, 32'hA5A5_0010);
        step();
        @(negedge clk);
        chk("t2 r1_data_out", r1_data_out, 32'hA5A5_0020);
        step(); step();

        // Enable low blocks grants
        en = 0; r0_valid = 1; r1_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4 r0_ready en0", r0_ready, 0);
            chk("t4 r1_ready en0", r1_ready, 0);
            chk("t4 bram_wr en0", bram_wr, 0);
            step();
        end
        en = 1;
        @(negedge clk);
        chk("t4 r0_ready first", r0_ready, 1);
        step();
        r0_valid = 0; r1_valid = 0;
        step(); step(); step();

        // Reset drops an in-flight read and restores r0 priority
        r0_valid = 1; r0_wr = 0; r0_addr = 10'h123;
        @(negedge clk);
        chk("t5 r0_ready", r0_ready, 1);
        step();
        rst = 1; r1_valid = 1; r1_wr = 0; r1_addr = 10'h200;
        @(negedge clk);
        chk("t5 r0_ready rst", r0_ready, 0);
        chk("t5 r1_ready rst", r1_ready, 0);
        step();
        @(negedge clk);
        chk("t5 r0_rsp_valid", r0_rsp_valid, 0);
        step();
        rst = 0;
        @(negedge clk);
        chk("t5 r0_ready after rst", r0_ready, 1);
        step();
        r0_valid = 0; r1_valid = 0;
        step(); step(); step();

        // r0 write followed immediately by r1 read of the same address
        r0_valid = 1; r0_wr = 1; r0_addr = 10'h3FF; r0_data_in = 32'h0000_0003;
        step();
        r0_valid = 0; r1_valid = 1; r1_wr = 0; r1_addr = 10'h3FF;
        @(negedge clk);
        chk("t6 r1_ready", r1_ready, 1);
        step();
        r1_valid = 0;
        step();
        @(negedge clk);
        chk("t6 r1_rsp_valid", r1_rsp_valid, 1);
        chk("t6 r1_data_out", r1_data_out, 32'h0000_0003);
        chk("t6 r0_rsp_valid", r0_rsp_valid, 0);
        step(); step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
